// File: rtl/fpu_addsub_sched.sv
// -----------------------------------------------------------------------------
// fpu_addsub_sched
//
// Round-robin scheduler that shares one combinational FPU add/sub datapath
// among NUM_REQ requesters. One requester is granted from IDLE, and its
// operands and op select are registered onto the datapath. During the single
// EXEC cycle the datapath settles, and the result plus {Z,C,N,V} are
// captured. The response is then held in RESP until it is accepted. The
// round-robin pointer moves to one past the served requester only after the
// response handshake.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   reqValid/reqReady per-requester request handshake (reqReady one-hot or 0)
//   reqSub            per-requester op select (1 = subtract)
//   reqOpA/reqOpB     packed operands, requester i at [i*BIT_WIDTH +: BIT_WIDTH]
//   dpSub/dpIn1/dpIn2 registered operands and op select to the datapath
//   dpOut/dpCondCodes combinational datapath result and {Z,C,N,V}
//   respValid/respReady response handshake
//   respData/respCondCodes/respId  captured result, flags, granted index
//   busy              high whenever the scheduler is not in IDLE
// -----------------------------------------------------------------------------
module fpu_addsub_sched #(
  parameter int BIT_WIDTH = 16,
  parameter int NUM_REQ   = 4,
  parameter int ID_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             reqValid,
  output logic [NUM_REQ-1:0]             reqReady,
  input  logic [NUM_REQ-1:0]             reqSub,
  input  logic [NUM_REQ*BIT_WIDTH-1:0]   reqOpA,
  input  logic [NUM_REQ*BIT_WIDTH-1:0]   reqOpB,
  output logic                           dpSub,
  output logic [BIT_WIDTH-1:0]           dpIn1,
  output logic [BIT_WIDTH-1:0]           dpIn2,
  input  logic [BIT_WIDTH-1:0]           dpOut,
  input  logic [3:0]                     dpCondCodes,
  output logic                           respValid,
  input  logic                           respReady,
  output logic [BIT_WIDTH-1:0]           respData,
  output logic [3:0]                     respCondCodes,
  output logic [ID_WIDTH-1:0]            respId,
  output logic                           busy
);

  // One extra bit so rrPtr + offset never overflows before the modulo fold.
  localparam int CW = ID_WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [ID_WIDTH-1:0]    rr_ptr_q, rr_ptr_d;
  logic                   dp_sub_q, dp_sub_d;
  logic [BIT_WIDTH-1:0]   dp_in1_q, dp_in1_d;
  logic [BIT_WIDTH-1:0]   dp_in2_q, dp_in2_d;
  logic                   resp_valid_q, resp_valid_d;
  logic [BIT_WIDTH-1:0]   resp_data_q, resp_data_d;
  logic [3:0]             resp_cc_q, resp_cc_d;
  logic [ID_WIDTH-1:0]    resp_id_q, resp_id_d;

  logic                   found_c;
  logic [ID_WIDTH-1:0]    win_c;
  logic [BIT_WIDTH-1:0]   op_a_c;
  logic [BIT_WIDTH-1:0]   op_b_c;
  logic                   sub_c;

  // Round-robin search: first valid requester at rrPtr, rrPtr+1, ... mod NUM_REQ.
  always_comb begin
    logic [CW-1:0] idx;
    // NOTE: every variable gets a default before any conditional assignment,
    // otherwise paths that skip an assignment infer a latch.
    found_c = 1'b0;
    win_c   = '0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr_q} + CW'(k);
      if (idx >= CW'(NUM_REQ)) begin
        idx = idx - CW'(NUM_REQ);
      end
      if (!found_c && reqValid[idx[ID_WIDTH-1:0]]) begin
        found_c = 1'b1;
        win_c   = idx[ID_WIDTH-1:0];
      end
    end
  end

  // Operand mux for the winner, plus the one-hot accept.
  always_comb begin
    op_a_c   = '0;
    op_b_c   = '0;
    sub_c    = 1'b0;
    reqReady = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_c == ID_WIDTH'(i)) begin
        op_a_c = reqOpA[i*BIT_WIDTH +: BIT_WIDTH];
        op_b_c = reqOpB[i*BIT_WIDTH +: BIT_WIDTH];
        sub_c  = reqSub[i];
      end
      // Gated by rst_n so no accept is signalled while reset is held,
      // even though the state register already reads IDLE.
      reqReady[i] = rst_n && (state_q == S_IDLE) && found_c &&
                    (win_c == ID_WIDTH'(i));
    end
  end

  // Next-state and datapath/response register updates.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    dp_sub_d     = dp_sub_q;
    dp_in1_d     = dp_in1_q;
    dp_in2_d     = dp_in2_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_cc_d    = resp_cc_q;
    resp_id_d    = resp_id_q;

    unique case (state_q)
      S_IDLE: begin
        if (found_c) begin
          dp_in1_d  = op_a_c;
          dp_in2_d  = op_b_c;
          dp_sub_d  = sub_c;
          resp_id_d = win_c;
          state_d   = S_EXEC;
        end
      end
      S_EXEC: begin
        resp_data_d  = dpOut;
        resp_cc_d    = dpCondCodes;
        resp_valid_d = 1'b1;
        state_d      = S_RESP;
      end
      S_RESP: begin
        // respValid is always high here, so respReady alone completes it.
        if (respReady) begin
          resp_valid_d = 1'b0;
          rr_ptr_d     = (resp_id_q == ID_WIDTH'(NUM_REQ - 1)) ?
                         '0 : resp_id_q + ID_WIDTH'(1);
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      dp_sub_q     <= 1'b0;
      dp_in1_q     <= '0;
      dp_in2_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_cc_q    <= '0;
      resp_id_q    <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      dp_sub_q     <= dp_sub_d;
      dp_in1_q     <= dp_in1_d;
      dp_in2_q     <= dp_in2_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_cc_q    <= resp_cc_d;
      resp_id_q    <= resp_id_d;
    end
  end

  assign dpSub         = dp_sub_q;
  assign dpIn1         = dp_in1_q;
  assign dpIn2         = dp_in2_q;
  assign respValid     = resp_valid_q;
  assign respData      = resp_data_q;
  assign respCondCodes = resp_cc_q;
  assign respId        = resp_id_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_fpu_addsub_sched.sv
// -----------------------------------------------------------------------------
// tb_fpu_addsub_sched
//
// Self-checking bench for fpu_addsub_sched with NUM_REQ=4 and BIT_WIDTH=16.
// A behavioural half-precision add/sub, built on real arithmetic, stands in
// for the FPU datapath. The bench tracks pending requests and the
// round-robin pointer in plain arrays and integers. From those, it predicts
// the winner, the latched operands and the response for each grant.
// -----------------------------------------------------------------------------
module tb_fpu_addsub_sched;

  localparam int BW = 16;
  localparam int N  = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    reqValid;
  logic [N-1:0]    reqReady;
  logic [N-1:0]    reqSub;
  logic [N*BW-1:0] reqOpA;
  logic [N*BW-1:0] reqOpB;
  logic            dpSub;
  logic [BW-1:0]   dpIn1;
  logic [BW-1:0]   dpIn2;
  logic [BW-1:0]   dpOut;
  logic [3:0]      dpCondCodes;
  logic            respValid;
  logic            respReady;
  logic [BW-1:0]   respData;
  logic [3:0]      respCondCodes;
  logic [IW-1:0]   respId;
  logic            busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference state: outstanding requests and the round-robin pointer.
  bit            pend_v [N];
  bit            pend_s [N];
  logic [15:0]   pend_a [N];
  logic [15:0]   pend_b [N];
  int            model_rr;
  int            grant_cyc;
  int            prev_grant;

  fpu_addsub_sched #(.BIT_WIDTH(BW), .NUM_REQ(N), .ID_WIDTH(IW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .reqValid      (reqValid),
    .reqReady      (reqReady),
    .reqSub        (reqSub),
    .reqOpA        (reqOpA),
    .reqOpB        (reqOpB),
    .dpSub         (dpSub),
    .dpIn1         (dpIn1),
    .dpIn2         (dpIn2),
    .dpOut         (dpOut),
    .dpCondCodes   (dpCondCodes),
    .respValid     (respValid),
    .respReady     (respReady),
    .respData      (respData),
    .respCondCodes (respCondCodes),
    .respId        (respId),
    .busy          (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- half-precision behavioural datapath ----------------
  function automatic real p2(input int e);
    real r;
    r = 1.0;
    if (e >= 0) for (int k = 0; k < e; k++) r = r * 2.0;
    else        for (int k = 0; k < -e; k++) r = r / 2.0;
    return r;
  endfunction

  function automatic real h2r(input logic [15:0] h);
    real m;
    if (h[14:10] == 5'd0) m = (real'(h[9:0]) / 1024.0) * p2(-14);
    else m = (1.0 + real'(h[9:0]) / 1024.0) * p2(int'(h[14:10]) - 15);
    return h[15] ? -m : m;
  endfunction

  function automatic logic [15:0] r2h(input real x);
    logic s;
    real  a;
    int   e;
    int   m;
    s = (x < 0.0);
    a = s ? -x : x;
    if (a < p2(-14)) return {s, 15'd0};
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    if (e > 15) return {s, 5'h1f, 10'd0};
    m = $rtoi((a - 1.0) * 1024.0);
    return {s, 5'(e + 15), 10'(m)};
  endfunction

  // Returns {Z,C,N,V,result}; C flags |a| < |b|.
  function automatic logic [19:0] dp_model(input logic [15:0] a, input logic [15:0] b,
                                           input logic s);
    real         ra;
    real         rb;
    logic [15:0] r;
    ra = h2r(a);
    rb = h2r(b);
    r  = r2h(s ? ra - rb : ra + rb);
    return {(r[14:0] == 15'd0), (a[14:0] < b[14:0]), r[15], (r[14:10] == 5'h1f), r};
  endfunction

  always_comb {dpCondCodes, dpOut} = dp_model(dpIn1, dpIn2, dpSub);

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      reqValid[i]          = pend_v[i];
      reqSub[i]            = pend_s[i];
      reqOpA[i*BW +: BW]   = pend_a[i];
      reqOpB[i*BW +: BW]   = pend_b[i];
    end
  endtask

  task automatic make_req(input int i, input logic [15:0] a, input logic [15:0] b,
                          input bit s);
    pend_v[i] = 1'b1;
    pend_a[i] = a;
    pend_b[i] = b;
    pend_s[i] = s;
    drive();
  endtask

  function automatic logic [15:0] rand_half();
    return {1'($urandom_range(0, 1)), 5'($urandom_range(10, 20)), 10'($urandom)};
  endfunction

  function automatic int model_winner();
    for (int k = 0; k < N; k++) begin
      if (pend_v[(model_rr + k) % N]) return (model_rr + k) % N;
    end
    return -1;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, ".reqReady"}, 32'(reqReady), 32'd0);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".respValid"}, 32'(respValid), 32'd0);
    check({tag, ".resp"}, {10'd0, respCondCodes, respId, respData}, 32'd0);
    check({tag, ".dp"}, {15'd0, dpSub, dpIn1}, 32'd0);
    check({tag, ".dpIn2"}, 32'(dpIn2), 32'd0);
  endtask

  // Called on a falling edge with the scheduler in IDLE. The task runs one
  // grant and response, then returns on a falling edge with it back in IDLE.
  task automatic serve(input int hold, input string tag);
    int          w;
    logic [19:0] exp;
    logic [15:0] ea;
    logic [15:0] eb;
    bit          es;
    #1;
    w = model_winner();
    check({tag, ".ready"}, 32'(reqReady), (w < 0) ? 32'd0 : 32'(1 << w));
    check({tag, ".busy_idle"}, 32'(busy), 32'd0);
    if (w < 0) begin
      @(negedge clk);
      return;
    end
    ea  = pend_a[w];
    eb  = pend_b[w];
    es  = pend_s[w];
    exp = dp_model(ea, eb, es);
    @(posedge clk);
    #1;
    grant_cyc = cyc;
    pend_v[w] = 1'b0;
    drive();
    @(negedge clk);
    check({tag, ".exec_ready"}, 32'(reqReady), 32'd0);
    check({tag, ".exec_busy"}, 32'(busy), 32'd1);
    check({tag, ".exec_valid"}, 32'(respValid), 32'd0);
    check({tag, ".dp_ops"}, {dpIn1, dpIn2}, {ea, eb});
    check({tag, ".dp_sub"}, 32'(dpSub), 32'(es));
    @(negedge clk);
    check({tag, ".resp_valid"}, 32'(respValid), 32'd1);
    check({tag, ".resp_data"}, 32'(respData), 32'(exp[15:0]));
    check({tag, ".resp_cc"}, 32'(respCondCodes), 32'(exp[19:16]));
    check({tag, ".resp_id"}, 32'(respId), 32'(w));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, ".hold_valid"}, 32'(respValid), 32'd1);
      check({tag, ".hold_data"}, {14'd0, respId, respData}, {14'd0, 2'(w), exp[15:0]});
      check({tag, ".hold_ready"}, 32'(reqReady), 32'd0);
    end
    respReady = 1'b1;
    @(posedge clk);
    #1;
    respReady = 1'b0;
    @(negedge clk);
    check({tag, ".done_valid"}, 32'(respValid), 32'd0);
    check({tag, ".done_busy"}, 32'(busy), 32'd0);
    model_rr = (w + 1) % N;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    for (int i = 0; i < N; i++) begin
      pend_v[i] = 1'b0; pend_s[i] = 1'b0; pend_a[i] = '0; pend_b[i] = '0;
    end
    drive();
    respReady = 1'b0;
    rst_n     = 1'b0;
    model_rr  = 0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");

    // Single add on requester 2.
    make_req(2, 16'h3C00, 16'h4000, 1'b0);
    rst_n = 1'b1;
    serve(0, "add");
    check("add.data_const", 32'(respData), 32'h4200);
    check("add.id_const", 32'(respId), 32'd2);
    check("add.zn", {30'd0, respCondCodes[3], respCondCodes[1]}, 32'd0);

    // Subtract on requester 0.
    make_req(0, 16'h4200, 16'h3C00, 1'b1);
    serve(0, "sub");
    check("sub.data_const", 32'(respData), 32'h4000);
    check("sub.id_const", 32'(respId), 32'd0);

    // Contention from reset: all four valid, expect 0,1,2,3 every 3 cycles.
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) make_req(i, rand_half(), rand_half(), 1'($urandom_range(0, 1)));
    #1;
    check("cont.ready_in_reset", 32'(reqReady), 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    model_rr = 0;
    for (int i = 0; i < N; i++) begin
      serve(0, "cont");
      check("cont.order", 32'(respId), 32'(i));
      if (i > 0) check("cont.period", 32'(grant_cyc - prev_grant), 32'd3);
      prev_grant = grant_cyc;
    end

    // Wrap-around: after serving 3, requesters 0 and 3 both valid -> 0 first.
    make_req(0, rand_half(), rand_half(), 1'b0);
    make_req(3, rand_half(), rand_half(), 1'b1);
    serve(0, "wrap");
    check("wrap.id", 32'(respId), 32'd0);
    pend_v[3] = 1'b0;
    drive();

    // Backpressure: requester 2 served with respReady low for 5 cycles,
    // while requester 0 waits.
    make_req(2, rand_half(), rand_half(), 1'b1);
    make_req(0, rand_half(), rand_half(), 1'b0);
    serve(5, "bp");
    pend_v[0] = 1'b0;
    drive();

    // Reset in EXEC: pointer is 3, requesters 1 and 3 valid -> 3 granted.
    make_req(1, rand_half(), rand_half(), 1'b0);
    make_req(3, rand_half(), rand_half(), 1'b1);
    #1;
    check("rst_exec.grant", 32'(reqReady), 32'b1000);
    @(negedge clk);
    check("rst_exec.in_exec", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_exec");
    repeat (2) @(negedge clk);
    check("rst_exec.no_resp", 32'(respValid), 32'd0);
    rst_n    = 1'b1;
    model_rr = 0;
    serve(0, "post_rst");
    check("post_rst.id", 32'(respId), 32'd1);

    // Randomised traffic: arrivals, withdrawals and variable backpressure.
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < N; i++) begin
        if (pend_v[i] && $urandom_range(0, 7) == 0) pend_v[i] = 1'b0;
        else if (!pend_v[i] && $urandom_range(0, 1) == 1)
          make_req(i, rand_half(), rand_half(), 1'($urandom_range(0, 1)));
      end
      drive();
      serve($urandom_range(0, 3), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
